// File: rtl/multdiv_controller.sv
// multdiv_controller
// Sequences the shared multi-cycle multiply/divide unit from the execute
// stage. A mul/div in execute gets a one-cycle start pulse to the unit. The
// pipeline stays stalled until the unit answers, the operation times out,
// or a flush kills it. The writeback is then presented for exactly one
// cycle. That writeback is either the destination register and the unit
// result, or an exception code written to $rstatus.
//
// Ports:
//   clock, reset   - system clock (rising edge), synchronous active-high reset
//   executeIR      - instruction currently in the execute stage
//   executeValid   - executeIR is a live instruction rather than a bubble
//   flush          - kill the in-flight operation (taken branch/jump)
//   md_result      - result word from the mul/div unit
//   md_resultRDY   - md_result / md_exception are valid this cycle
//   md_exception   - overflow or divide-by-zero, qualified by md_resultRDY
//   ctrl_MULT      - one-cycle start pulse for a multiply
//   ctrl_DIV       - one-cycle start pulse for a divide
//   stall          - freeze fetch/decode/execute (ORed into global stall)
//   result_valid   - writeback fields below are valid this cycle
//   result_we      - register write enable
//   result_rd      - destination register
//   result_data    - write data
//   busy_count     - cycles spent in BUSY, for debug and perf counters
module multdiv_controller #(
    parameter int TIMEOUT     = 40,
    parameter int RSTATUS_REG = 30,
    parameter int MUL_EXC     = 4,
    parameter int DIV_EXC     = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] executeIR,
    input  logic        executeValid,
    input  logic        flush,
    input  logic [31:0] md_result,
    input  logic        md_resultRDY,
    input  logic        md_exception,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        result_valid,
    output logic        result_we,
    output logic [4:0]  result_rd,
    output logic [31:0] result_data,
    output logic [5:0]  busy_count
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} ctrlState_t;

    ctrlState_t state, nextState;

    logic        isMul, isDiv, isMD;
    logic        issue, capture, timeoutHit, startCycle;
    logic        ctrlMultReg, ctrlDivReg;
    logic [4:0]  rdLatched;
    logic        opIsDiv;
    logic [31:0] resData;
    logic        resExc;
    logic [5:0]  busyCount;
    logic        unusedIrBits;

    // Decode: R-type opcode 00000 with the ALU op field selecting mul or div.
    // Bubbles never count as a mul/div.
    assign isMul = (executeIR[31:27] == 5'b00000) && (executeIR[6:2] == 5'b00110);
    assign isDiv = (executeIR[31:27] == 5'b00000) && (executeIR[6:2] == 5'b00111);
    assign isMD  = (isMul || isDiv) && executeValid;

    // Source register fields and shamt are irrelevant to this controller.
    assign unusedIrBits = ^{executeIR[21:7], executeIR[1:0]};

    // The start pulse is high exactly in the first BUSY cycle. A ready seen
    // then belongs to whatever the unit was doing before, so it is ignored.
    assign startCycle = ctrlMultReg | ctrlDivReg;

    assign ctrl_MULT  = ctrlMultReg;
    assign ctrl_DIV   = ctrlDivReg;
    assign busy_count = busyCount;

    // State register. Reset always lands in IDLE, even mid-operation. The
    // unit is simply abandoned and never re-pulsed.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and output decode. The stall in IDLE is combinational, so a
    // mul/div freezes in execute from its very first cycle. In BUSY, flush
    // outranks both ready and timeout. DONE lasts one cycle and never
    // decodes, so the instruction still sitting in execute is not re-issued.
    always_comb begin
        nextState    = state;
        stall        = 1'b0;
        issue        = 1'b0;
        capture      = 1'b0;
        timeoutHit   = 1'b0;
        result_valid = 1'b0;
        result_we    = 1'b0;
        result_rd    = 5'd0;
        result_data  = 32'd0;
        case (state)
            IDLE: begin
                if (isMD && !flush) begin
                    issue     = 1'b1;
                    stall     = 1'b1;
                    nextState = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (flush) begin
                    nextState = IDLE;
                end else if (md_resultRDY && !startCycle) begin
                    capture   = 1'b1;
                    nextState = DONE;
                end else if (busyCount == 6'(TIMEOUT)) begin
                    timeoutHit = 1'b1;
                    nextState  = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                nextState    = IDLE;
                if (resExc) begin
                    result_we   = 1'b1;
                    result_rd   = 5'(RSTATUS_REG);
                    result_data = opIsDiv ? 32'(DIV_EXC) : 32'(MUL_EXC);
                end else begin
                    result_we   = (rdLatched != 5'd0);
                    result_rd   = rdLatched;
                    result_data = resData;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath registers. On issue, the destination and op type are latched.
    // The start pulse is registered, and the busy counter starts at one, so
    // it reads as the index of the current BUSY cycle. It saturates at 63
    // and clears when the operation ends or is flushed. A timeout forces an
    // exception in place of a unit result.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrlMultReg <= 1'b0;
            ctrlDivReg  <= 1'b0;
            rdLatched   <= 5'd0;
            opIsDiv     <= 1'b0;
            resData     <= 32'd0;
            resExc      <= 1'b0;
            busyCount   <= 6'd0;
        end else begin
            ctrlMultReg <= issue && isMul;
            ctrlDivReg  <= issue && isDiv;

            if (issue) begin
                rdLatched <= executeIR[26:22];
                opIsDiv   <= isDiv;
                busyCount <= 6'd1;
            end else if (state == BUSY) begin
                if (flush) begin
                    busyCount <= 6'd0;
                end else if (busyCount != 6'd63) begin
                    busyCount <= busyCount + 6'd1;
                end
            end else if (state == DONE) begin
                busyCount <= 6'd0;
            end

            if (capture) begin
                resData <= md_result;
                resExc  <= md_exception;
            end else if (timeoutHit) begin
                resData <= 32'd0;
                resExc  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/multdiv_controller.md
Name: multdiv_controller

Overview:
- Sequences the shared multi-cycle multiply/divide unit from the execute stage.
- Decodes the execute-stage instruction, issues a one-cycle start pulse to the unit, and holds the pipeline stalled until the result arrives.
- Formats the writeback: destination register and data, or a $rstatus exception write.
- Sits beside the hazard interlock. Its stall is ORed into the global pipeline stall.

Parameters:
- TIMEOUT, 40, BUSY cycles allowed before the operation is abandoned as an exception.
- RSTATUS_REG, 30, register written on exception.
- MUL_EXC, 4, $rstatus code for a mul exception or timeout.
- DIV_EXC, 5, $rstatus code for a div exception or timeout.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- executeIR  in  32  instruction in the execute stage.
- executeValid  in  1  executeIR is a live instruction (not a bubble).
- flush  in  1  kill the in-flight op (branch/jump taken).
- md_result  in  32  unit result.
- md_resultRDY  in  1  unit result valid.
- md_exception  in  1  overflow or divide-by-zero, qualified by md_resultRDY.
- ctrl_MULT  out  1  start multiply, one-cycle pulse.
- ctrl_DIV  out  1  start divide, one-cycle pulse.
- stall  out  1  freeze fetch/decode/execute.
- result_valid  out  1  writeback fields valid this cycle.
- result_we  out  1  register write enable.
- result_rd  out  5  destination register.
- result_data  out  32  write data.
- busy_count  out  6  cycles spent in BUSY, for debug and perf counters.

Behaviour:
Decode:
- isMul = opcode[31:27]==00000 and ALUop[6:2]==00110.
- isDiv = opcode[31:27]==00000 and ALUop[6:2]==00111.
- isMD = (isMul or isDiv) and executeValid.

States: IDLE, BUSY, DONE. Reset puts the FSM in IDLE and clears all registered outputs, busy_count, and latched rd/op.

IDLE:
- isMD and not flush: latch rd = executeIR[26:22] and op type; go to BUSY. The registered start pulse (ctrl_MULT or ctrl_DIV) is high during the first BUSY cycle only.
- isMD and flush: no issue, stay IDLE.
- stall = isMD and not flush. This is combinational, so the mul/div is frozen in execute from its first cycle.

BUSY:
- stall = 1.
- busy_count increments each cycle and saturates at 63.
- md_resultRDY is ignored in the start-pulse cycle.
- md_resultRDY seen later: capture md_result and md_exception, go to DONE.
- busy_count reaches TIMEOUT before RDY: go to DONE with the exception forced.
- flush in BUSY (same cycle as RDY included): go to IDLE, nothing captured, no result_valid.
- flush has priority over both RDY and timeout.

DONE (exactly one cycle):
- stall = 0, so the pipeline advances at the end of this cycle. result_valid = 1.
- Normal result: result_rd = latched rd, result_data = md_result, result_we = (rd != 0).
- Exception: result_rd = RSTATUS_REG, result_data = MUL_EXC or DIV_EXC by op, result_we = 1.
- Next state is always IDLE. No decode happens in DONE, so the still-present instruction is never re-issued.
- busy_count is cleared on DONE→IDLE.

Other rules:
- Back-to-back mul/div: the second op is issued in the IDLE cycle after DONE. Minimum spacing is 3 cycles per op plus unit latency.
- result_valid, result_we, result_rd and result_data are 0 outside DONE.
- ctrl_MULT and ctrl_DIV are never high together.
- Reset asserted mid-BUSY: IDLE next cycle, stall low, no pulse and no result. The unit is not re-pulsed.

Test Plan:
1. mul $5,$2,$3 with executeValid=1; RDY after 8 BUSY cycles with md_result=0x00000030 → ctrl_MULT high in BUSY cycle 1 only; stall high from the issue cycle through BUSY; DONE gives result_rd=5, result_data=0x30, result_we=1; stall low in DONE.
2. div $7,$1,$0; RDY with md_exception=1 → result_rd=30, result_data=5, result_we=1.
3. mul $0,...; RDY with result 0x1234 → result_valid=1, result_we=0.
4. div issued; RDY never arrives → DONE after TIMEOUT=40 BUSY cycles with result_rd=30, result_data=5; busy_count=40 in the last BUSY cycle.
5. flush asserted in BUSY cycle 3, and separately in the same cycle as RDY → IDLE next cycle, stall low, no result_valid. A subsequent mul issues normally.
6. reset in BUSY cycle 2, plus back-to-back mul then div → all outputs 0 after reset; for the back-to-back case, ctrl_DIV pulses exactly once, in the BUSY cycle following the IDLE that comes after the mul's DONE.
